// File: rtl/conv_pkg.sv
// Shared constants and arithmetic helpers for the streaming 2-D convolution engine.
package conv_pkg;

  localparam int ACC_WIDTH_DEF = 40;

  function automatic int tap_index(input int row, input int col, input int k);
    return row * k + col;
  endfunction

  // Identity kernel: only the centre tap is set, to 1.0 in the coefficient Q format.
  function automatic logic signed [63:0] identity_coef(input int tap, input int k, input int shift);
    return (tap == tap_index(k / 2, k / 2, k)) ? (64'sd1 <<< shift) : 64'sd0;
  endfunction

  // Round half up by dropping `shift` fractional bits, then clamp to a dw-bit signed range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift, input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: the output is the sample shifted in DEPTH accepts earlier.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         shift_en,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: non-blocking assignments let every tap read the pre-edge value of its neighbour,
  // so the loop below is a true shift rather than a ripple of din through all stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the memory is cleared on reset so a fresh frame starts from known zeros;
      // this forces flops instead of RAM, which is acceptable at one image row.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK convolution: raster pixels in, line-buffered window, loadable signed kernel,
// three-stage MAC pipeline with round-half-up and saturation, valid/ready on both sides.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int OUT_SHIFT   = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          coef_wr_en,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]    coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0]                  coef_wr_data,
  input  logic                                          pix_valid,
  output logic                                          pix_ready,
  input  logic signed [DATA_WIDTH-1:0]                  pix_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [DATA_WIDTH-1:0]                  out_data,
  output logic                                          out_last,
  output logic                                          busy
);

  localparam int K    = KERNEL_SIZE;
  localparam int TAPS = K * K;
  localparam int AW   = $clog2(TAPS);
  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int RW   = $clog2(IMG_HEIGHT);
  localparam int PW   = DATA_WIDTH + COEF_WIDTH;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FULL = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(K - 1);
  localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          adv_en, accept, complete, frame_end;

  logic signed [DATA_WIDTH-1:0] lb_in   [K-1];
  logic signed [DATA_WIDTH-1:0] lb_out  [K-1];
  logic signed [DATA_WIDTH-1:0] col_in  [K];
  logic signed [DATA_WIDTH-1:0] win     [K][K];
  logic signed [DATA_WIDTH-1:0] win_nxt [K][K];
  logic signed [COEF_WIDTH-1:0] coef    [TAPS];

  logic signed [PW-1:0]         prod      [K][K];
  logic signed [ACC_WIDTH-1:0]  row_sum_c [K];
  logic signed [ACC_WIDTH-1:0]  row_sum   [K];
  logic signed [ACC_WIDTH-1:0]  total_c;
  logic signed [DATA_WIDTH-1:0] sat_c;
  logic                         s1_valid, s1_last, s2_valid, s2_last;

  // A single advance enable freezes every stage, the line buffers and the counters together.
  assign adv_en    = !out_valid || out_ready;
  assign pix_ready = adv_en;
  assign accept    = pix_valid && adv_en;
  assign complete  = (row >= ROW_FULL) && (col >= COL_FULL);
  assign frame_end = (row == ROW_LAST) && (col == COL_LAST);
  assign busy      = (row != '0) || (col != '0) || s1_valid || s2_valid || out_valid;

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_in[i] = pix_data;
    end else begin : g_chain
      assign lb_in[i] = lb_out[i-1];
    end
    conv_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb (
      .clk      (clk),
      .reset    (reset),
      .shift_en (accept),
      .din      (lb_in[i]),
      .dout     (lb_out[i])
    );
  end

  // Row 0 of the window is the oldest image row; the incoming pixel lands in the bottom row.
  always_comb begin
    col_in[K-1] = pix_data;
    for (int r = 0; r < K - 1; r++) col_in[r] = lb_out[K-2-r];
  end

  // NOTE: every element is assigned on every pass, so no latch can be inferred here.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_nxt[r][c] = win[r][c+1];
      win_nxt[r][K-1] = col_in[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (accept) begin
      win <= win_nxt;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Writes only land between frames; busy=0 implies the next accept is pixel (0,0),
  // which never completes a window, so no same-cycle bypass is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < TAPS; t++) coef[t] <= COEF_WIDTH'(identity_coef(t, K, OUT_SHIFT));
    end else if (coef_wr_en && !busy && (coef_wr_addr <= TAP_LAST)) begin
      coef[coef_wr_addr] <= coef_wr_data;
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      row_sum_c[r] = '0;
      for (int c = 0; c < K; c++) row_sum_c[r] = row_sum_c[r] + ACC_WIDTH'(prod[r][c]);
    end
    total_c = '0;
    for (int r = 0; r < K; r++) total_c = total_c + row_sum[r];
    sat_c = DATA_WIDTH'(round_sat(64'(total_c), OUT_SHIFT, DATA_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      for (int r = 0; r < K; r++) begin
        row_sum[r] <= '0;
        for (int c = 0; c < K; c++) prod[r][c] <= '0;
      end
    end else if (adv_en) begin
      s1_valid <= pix_valid && complete;
      s1_last  <= frame_end;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) prod[r][c] <= win_nxt[r][c] * coef[tap_index(r, c, K)];
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      row_sum  <= row_sum_c;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= sat_c;
        out_last <= s2_last;
      end
    end
  end

endmodule
